// File: rtl/gbt_tx_arbiter.sv
// gbt_tx_arbiter: round-robin framer of NREQ readout FIFOs onto the 16-bit GBT link (header, data, trailer).
// Optional test-pattern generator enabled by defining GBT_ARB_TEST_PAT_EN.
`timescale 1ns/1ps
module gbt_tx_arbiter #(
  parameter int NREQ = 4,
  parameter int MAX_BURST = 256,
  parameter logic [15:0] IDLE_WORD = 16'h50BC,
  parameter logic [3:0] HDR_TAG = 4'hA,
  parameter logic [3:0] TRL_TAG = 4'hE
) (
  input  logic CLK40,
  input  logic RST,
  input  logic ENA,
  input  logic [NREQ-1:0] READY,
  input  logic [NREQ-1:0] MT,
  input  logic [16*NREQ-1:0] DIN,
`ifdef GBT_ARB_TEST_PAT_EN
  input  logic TEST_MODE,
`endif
  output logic [NREQ-1:0] RD_EN,
  output logic [15:0] DOUT,
  output logic DVALID,
  output logic [NREQ-1:0] GRANT,
  output logic BUSY
);
`ifdef GBT_ARB_TEST_PAT_EN
  typedef enum logic [2:0] {IDLE, HDR, READ, TRL, TEST} state_t;
`else
  typedef enum logic [2:0] {IDLE, HDR, READ, TRL} state_t;
`endif
  localparam logic [10:0] MAXB = 11'(MAX_BURST);
  state_t state, nxt;
  logic [1:0] g, rr_ptr, pick;
  logic [10:0] cnt;
  logic [NREQ-1:0] onehot;
  logic [15:0] din_g, dw;
  logic found, rd, rd_d1, dv;
`ifdef GBT_ARB_TEST_PAT_EN
  logic [15:0] pat;
`endif
  assign onehot = NREQ'(1) << g;
  assign din_g = DIN[16*int'(g) +: 16];
  assign rd = (state == HDR || state == READ) && !(|(MT & onehot)) && cnt < MAXB;
  assign RD_EN = rd ? onehot : '0;
  assign GRANT = (state == HDR || state == READ || state == TRL) ? onehot : '0;
  assign BUSY = state != IDLE;
  // Scan downward so the nearest requester after rr_ptr is the last one assigned.
  always_comb begin
    found = 1'b0;
    pick = '0;
    for (int k = NREQ; k >= 1; k--) begin
      if (READY[(int'(rr_ptr) + k) % NREQ]) begin
        found = 1'b1;
        pick = 2'((int'(rr_ptr) + k) % NREQ);
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
`ifdef GBT_ARB_TEST_PAT_EN
      IDLE: nxt = TEST_MODE ? TEST : (ENA && found) ? HDR : IDLE;
      TEST: nxt = TEST_MODE ? TEST : IDLE;
`else
      IDLE: nxt = (ENA && found) ? HDR : IDLE;
`endif
      HDR:  nxt = READ;
      READ: nxt = rd ? READ : TRL;
      TRL:  nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_comb begin
    dv = state == HDR || state == TRL || rd_d1;
    dw = state == HDR ? {HDR_TAG, 10'd0, g} :
         state == TRL ? {TRL_TAG, cnt[9:0], g} :
         rd_d1 ? din_g : IDLE_WORD;
`ifdef GBT_ARB_TEST_PAT_EN
    if (state == TEST) begin
      dv = 1'b1;
      dw = pat;
    end
`endif
  end
  always_ff @(posedge CLK40) begin
    if (RST) begin
      state <= IDLE;
      g <= '0;
      rr_ptr <= 2'(NREQ - 1);
      cnt <= '0;
      rd_d1 <= 1'b0;
      DOUT <= IDLE_WORD;
      DVALID <= 1'b0;
`ifdef GBT_ARB_TEST_PAT_EN
      pat <= '0;
`endif
    end else begin
      state <= nxt;
      rd_d1 <= rd;
      DOUT <= dw;
      DVALID <= dv;
      if (state == IDLE && nxt == HDR) begin
        g <= pick;
        rr_ptr <= pick;
        cnt <= '0;
      end else if (rd) begin
        cnt <= cnt + 11'd1;
      end
`ifdef GBT_ARB_TEST_PAT_EN
      pat <= state == TEST ? pat + 16'd1 : '0;
`endif
    end
  end
endmodule
